// File: rtl/uart_rx_oversample.sv
// ---------------------------------------------------------------------------
// uart_rx_oversample
// UART receive engine driven by a SAMPLE-times oversampling tick enable.
// Recovers LSB-first frames (start, DATA_SIZE data bits, optional parity,
// one stop bit) and commits each frame as a one-clk data_valid pulse that
// can feed a FIFO write port directly. Parity, stop, break and overflow
// status are committed together with the frame and hold until the next one.
//
// Ports:
//   clk             system clock
//   reset_n         asynchronous active-low reset
//   sample_tick     one-clk enable at BAUD_RATE*SAMPLE
//   rx_en           receiver enable; dropping it mid-frame aborts the frame
//   serial_data_in  asynchronous serial line, idles high
//   fifo_full       receive FIFO full; a frame committed while high is dropped
//   data_out        last committed byte
//   data_valid      one-clk pulse, data_out holds a new byte
//   parity_error    parity mismatch in the last committed frame
//   stop_error      stop bit sampled low in the last committed frame
//   break_error     whole last frame was low
//   overflow_error  last frame was dropped because fifo_full was high
//   busy            receiver is in any state other than IDLE
// ---------------------------------------------------------------------------
module uart_rx_oversample #(
    parameter int DATA_SIZE  = 8,
    parameter int SAMPLE     = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sample_tick,
    input  logic                 rx_en,
    input  logic                 serial_data_in,
    input  logic                 fifo_full,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_error,
    output logic                 stop_error,
    output logic                 break_error,
    output logic                 overflow_error,
    output logic                 busy
);

    localparam int TICK_W = $clog2(SAMPLE);
    localparam int BIT_W  = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(1'b0);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1'b1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(SAMPLE/2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_ZERO  = BIT_W'(1'b0);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1'b1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_SIZE - 1);
    localparam logic              PAR_ODD_BIT = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_BRK_WAIT = 3'd5
    } state_t;

    // Expected parity bit for a data word.
    function automatic logic calc_parity(input logic [DATA_SIZE-1:0] d);
        return (^d) ^ PAR_ODD_BIT;
    endfunction

    state_t               state_r, state_nx;
    logic                 sync1_r, rx_s, rx_prev_r;
    logic [TICK_W-1:0]    tick_cnt_r, tick_nx;
    logic [BIT_W-1:0]     bit_cnt_r, bit_nx;
    logic [DATA_SIZE-1:0] shift_r, shift_nx;
    logic                 par_err_r, par_err_nx;
    logic                 par_bit_r, par_bit_nx;
    logic                 commit_s, stop_low_s, brk_s, fall_s;

    logic [DATA_SIZE-1:0] data_out_r;
    logic                 data_valid_r, parity_error_r, stop_error_r;
    logic                 break_error_r, overflow_error_r, busy_r;

    assign fall_s = rx_prev_r & ~rx_s;

    // Two-flop synchroniser plus delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            sync1_r   <= serial_data_in;
            rx_s      <= sync1_r;
            rx_prev_r <= rx_s;
        end
    end

    // FSM state, counters and frame datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= TICK_ZERO;
            bit_cnt_r  <= BIT_ZERO;
            shift_r    <= {DATA_SIZE{1'b0}};
            par_err_r  <= 1'b0;
            par_bit_r  <= 1'b0;
        end else begin
            state_r    <= state_nx;
            tick_cnt_r <= tick_nx;
            bit_cnt_r  <= bit_nx;
            shift_r    <= shift_nx;
            par_err_r  <= par_err_nx;
            par_bit_r  <= par_bit_nx;
        end
    end

    // Next-state logic; counters only move on sample_tick, abort beats commit.
    always_comb begin
        state_nx   = state_r;
        tick_nx    = tick_cnt_r;
        bit_nx     = bit_cnt_r;
        shift_nx   = shift_r;
        par_err_nx = par_err_r;
        par_bit_nx = par_bit_r;
        commit_s   = 1'b0;
        stop_low_s = 1'b0;
        brk_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_en && fall_s) begin
                    state_nx = ST_START;
                    tick_nx  = TICK_ZERO;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_START: begin
                if (!rx_en) begin
                    state_nx = ST_IDLE;
                end else if (sample_tick) begin
                    if (tick_cnt_r == TICK_MID) begin
                        if (rx_s) begin
                            state_nx = ST_IDLE;  // false start, nothing committed
                        end else begin
                            state_nx   = ST_DATA;
                            tick_nx    = TICK_ZERO;
                            bit_nx     = BIT_ZERO;
                            par_err_nx = 1'b0;
                            par_bit_nx = 1'b0;
                        end
                    end else begin
                        tick_nx = tick_cnt_r + TICK_ONE;
                    end
                end else begin
                    state_nx = ST_START;
                end
            end
            ST_DATA: begin
                if (!rx_en) begin
                    state_nx = ST_IDLE;
                end else if (sample_tick) begin
                    if (tick_cnt_r == TICK_LAST) begin
                        tick_nx  = TICK_ZERO;
                        shift_nx = {rx_s, shift_r[DATA_SIZE-1:1]};
                        if (bit_cnt_r == BIT_LAST) begin
                            bit_nx   = BIT_ZERO;
                            state_nx = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_nx = bit_cnt_r + BIT_ONE;
                        end
                    end else begin
                        tick_nx = tick_cnt_r + TICK_ONE;
                    end
                end else begin
                    state_nx = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (!rx_en) begin
                    state_nx = ST_IDLE;
                end else if (sample_tick) begin
                    if (tick_cnt_r == TICK_LAST) begin
                        tick_nx    = TICK_ZERO;
                        par_bit_nx = rx_s;
                        par_err_nx = rx_s ^ calc_parity(shift_r);
                        state_nx   = ST_STOP;
                    end else begin
                        tick_nx = tick_cnt_r + TICK_ONE;
                    end
                end else begin
                    state_nx = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (!rx_en) begin
                    state_nx = ST_IDLE;
                end else if (sample_tick) begin
                    if (tick_cnt_r == TICK_LAST) begin
                        tick_nx    = TICK_ZERO;
                        commit_s   = 1'b1;
                        stop_low_s = ~rx_s;
                        // Break: stop, data and parity all sampled low.
                        brk_s      = ~rx_s & (shift_r == {DATA_SIZE{1'b0}}) & ~par_bit_r;
                        state_nx   = brk_s ? ST_BRK_WAIT : ST_IDLE;
                    end else begin
                        tick_nx = tick_cnt_r + TICK_ONE;
                    end
                end else begin
                    state_nx = ST_STOP;
                end
            end
            ST_BRK_WAIT: begin
                // Wait for the line to return high so a held-low line never starts a frame.
                if (rx_s) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_BRK_WAIT;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Registered outputs: frame commit, one-clk valid pulse and busy flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_r       <= {DATA_SIZE{1'b0}};
            data_valid_r     <= 1'b0;
            parity_error_r   <= 1'b0;
            stop_error_r     <= 1'b0;
            break_error_r    <= 1'b0;
            overflow_error_r <= 1'b0;
            busy_r           <= 1'b0;
        end else begin
            data_valid_r <= 1'b0;
            busy_r       <= (state_nx != ST_IDLE);
            if (commit_s) begin
                parity_error_r   <= par_err_r;
                stop_error_r     <= stop_low_s;
                break_error_r    <= brk_s;
                overflow_error_r <= fifo_full;
                if (!fifo_full) begin
                    data_out_r   <= brk_s ? {DATA_SIZE{1'b0}} : shift_r;
                    data_valid_r <= 1'b1;
                end
            end
        end
    end

    assign data_out       = data_out_r;
    assign data_valid     = data_valid_r;
    assign parity_error   = parity_error_r;
    assign stop_error     = stop_error_r;
    assign break_error    = break_error_r;
    assign overflow_error = overflow_error_r;
    assign busy           = busy_r;

endmodule
